// File: rtl/switch_input_conditioner.sv
// Two-flop synchroniser plus per-bit debounce for the slide switches; emits a clean vector and change strobe.
// Define SW_GLITCH_COUNT_EN to add the saturating glitch_count output.
module switch_input_conditioner #(
   parameter int NSW            = 10,
   parameter int DEBOUNCE_COUNT = 100000,
   parameter int CNT_BITS       = 17
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NSW-1:0]      sw_raw,
   output logic [NSW-1:0]      sw_stable,
   output logic                sw_changed,
   output logic [NSW-1:0]      changed_mask
`ifdef SW_GLITCH_COUNT_EN
   ,
   output logic [15:0]         glitch_count
`endif
);

   localparam logic [CNT_BITS-1:0] LP_CNT_LAST = CNT_BITS'(DEBOUNCE_COUNT - 1);
   localparam logic [CNT_BITS-1:0] LP_CNT_ZERO = {CNT_BITS{1'b0}};

   logic [NSW-1:0]      r_sync1;
   logic [NSW-1:0]      r_sync2;
   logic [NSW-1:0]      r_stable;
   logic [NSW-1:0]      r_mask;
   logic                r_changed;
   logic [CNT_BITS-1:0] r_cnt [NSW];

   logic [NSW-1:0]      w_stable_nxt;
   logic [NSW-1:0]      w_mask_nxt;
   logic [CNT_BITS-1:0] w_cnt_nxt [NSW];

   // Per-bit debounce decision: any return to the stable level discards the partial count.
   always_comb begin
      w_stable_nxt = r_stable;
      w_mask_nxt   = {NSW{1'b0}};
      for (int i = 0; i < NSW; i++) begin
         w_cnt_nxt[i] = LP_CNT_ZERO;
         if (r_sync2[i] == r_stable[i]) begin
            w_cnt_nxt[i] = LP_CNT_ZERO;
         end else if (r_cnt[i] == LP_CNT_LAST) begin
            w_stable_nxt[i] = r_sync2[i];
            w_mask_nxt[i]   = 1'b1;
         end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_BITS'(1);
         end
      end
   end

   // Synchroniser, debounce counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1   <= {NSW{1'b0}};
         r_sync2   <= {NSW{1'b0}};
         r_stable  <= {NSW{1'b0}};
         r_mask    <= {NSW{1'b0}};
         r_changed <= 1'b0;
         for (int i = 0; i < NSW; i++) begin
            r_cnt[i] <= LP_CNT_ZERO;
         end
      end else begin
         r_sync1   <= sw_raw;
         r_sync2   <= r_sync1;
         r_stable  <= w_stable_nxt;
         r_mask    <= w_mask_nxt;
         r_changed <= |w_mask_nxt;
         for (int i = 0; i < NSW; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
      end
   end

   assign sw_stable    = r_stable;
   assign changed_mask = r_mask;
   assign sw_changed   = r_changed;

`ifdef SW_GLITCH_COUNT_EN
   logic [15:0] r_glitch_count;
   logic        w_any_glitch;

   // A glitch is a bit that had started counting and fell back to its stable level.
   always_comb begin
      w_any_glitch = 1'b0;
      for (int i = 0; i < NSW; i++) begin
         w_any_glitch = w_any_glitch | ((r_sync2[i] == r_stable[i]) && (r_cnt[i] != LP_CNT_ZERO));
      end
   end

   // Saturating glitch counter, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_glitch_count <= 16'h0000;
      end else if (w_any_glitch && (r_glitch_count != 16'hFFFF)) begin
         r_glitch_count <= r_glitch_count + 16'h0001;
      end else begin
         r_glitch_count <= r_glitch_count;
      end
   end

   assign glitch_count = r_glitch_count;
`endif

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Self-checking bench for switch_input_conditioner (DEBOUNCE_COUNT=4): directed scenarios plus random
// stimulus, compared against a sliding-window reference model of the debounce rules.
module tb_switch_input_conditioner;

   localparam int NSW = 10;
   localparam int D   = 4;
   localparam int CB  = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic [NSW-1:0]  sw_raw;
   logic [NSW-1:0]  sw_stable;
   logic            sw_changed;
   logic [NSW-1:0]  changed_mask;
`ifdef SW_GLITCH_COUNT_EN
   logic [15:0]     glitch_count;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   logic [NSW-1:0] m_stable;
   logic [NSW-1:0] m_mask;
   logic           m_changed;
   logic [15:0]    m_glitch;
   logic [NSW-1:0] q_raw[$];
   logic [NSW-1:0] q_s2[$];

   switch_input_conditioner #(
      .NSW(NSW),
      .DEBOUNCE_COUNT(D),
      .CNT_BITS(CB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sw_raw(sw_raw),
      .sw_stable(sw_stable),
      .sw_changed(sw_changed),
      .changed_mask(changed_mask)
`ifdef SW_GLITCH_COUNT_EN
      ,
      .glitch_count(glitch_count)
`endif
   );

   always #5 clk = ~clk;

   // Model: the synchronised level seen at edge k is the raw pin sampled at edge k-2;
   // a bit flips when the last D synchronised levels all differ from the stable level.
   task automatic model_step();
      logic [NSW-1:0] s_in;
      logic [NSW-1:0] all_diff;
      logic           g;
      if (reset) begin
         q_raw.delete();
         q_s2.delete();
         m_stable  = '0;
         m_mask    = '0;
         m_changed = 1'b0;
         m_glitch  = 16'h0000;
         return;
      end
      s_in = (q_raw.size() >= 2) ? q_raw[q_raw.size()-2] : '0;
      q_s2.push_back(s_in);
      g = 1'b0;
      if (q_s2.size() >= 2)
         g = |((q_s2[q_s2.size()-2] ^ m_stable) & ~(q_s2[q_s2.size()-1] ^ m_stable));
      all_diff = '0;
      if (q_s2.size() >= D) begin
         all_diff = '1;
         for (int j = 0; j < D; j++)
            all_diff = all_diff & (q_s2[q_s2.size()-1-j] ^ m_stable);
      end
      m_mask    = all_diff;
      m_stable  = m_stable ^ all_diff;
      m_changed = |all_diff;
      if (g && m_glitch != 16'hFFFF) m_glitch = m_glitch + 16'h0001;
      q_raw.push_back(sw_raw);
      if (q_raw.size() > 4) void'(q_raw.pop_front());
      if (q_s2.size() > 8) void'(q_s2.pop_front());
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      sw_raw = '0;
      tick();
      reset  = 1'b0;
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      sw_raw = 10'h3FF;
      tick();
      tick();
      n_checks++;
      if (sw_stable !== 10'h000 || sw_changed !== 1'b0 || changed_mask !== 10'h000)
         $display("FAIL reset_state stable=%h chg=%b mask=%h required 000/0/000", sw_stable, sw_changed, changed_mask);
      else n_pass++;
      reset = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         logic [NSW-1:0] exp_s;
         logic           exp_c;
         tick();
         exp_s = (e >= 6) ? 10'h3FF : 10'h000;
         exp_c = (e == 6);
         n_checks++;
         if (sw_stable !== exp_s || sw_changed !== exp_c || changed_mask !== (exp_c ? 10'h3FF : 10'h000))
            $display("FAIL reset_release e=%0d stable=%h chg=%b mask=%h required %h/%b", e, sw_stable, sw_changed, changed_mask, exp_s, exp_c);
         else n_pass++;
         n_checks++;
         if (sw_stable !== m_stable || changed_mask !== m_mask || sw_changed !== m_changed)
            $display("FAIL reset_model e=%0d stable=%h/%h mask=%h/%h", e, sw_stable, m_stable, changed_mask, m_mask);
         else n_pass++;
      end
   endtask

   task automatic test_glitch();
      do_reset();
      tick();
      tick();
      sw_raw = 10'h008;
      for (int e = 0; e < 12; e++) begin
         if (e == 3) sw_raw = 10'h000;
         tick();
         n_checks++;
         if (sw_stable !== 10'h000 || sw_changed !== 1'b0 || sw_stable !== m_stable)
            $display("FAIL glitch_reject e=%0d stable=%h chg=%b required 000/0", e, sw_stable, sw_changed);
         else n_pass++;
      end
`ifdef SW_GLITCH_COUNT_EN
      n_checks++;
      if (glitch_count !== 16'd1 || glitch_count !== m_glitch)
         $display("FAIL glitch_count got=%0d required 1", glitch_count);
      else n_pass++;
`endif
   endtask

   task automatic test_pattern_005();
      sw_raw = 10'h005;
      for (int e = 1; e <= 7; e++) begin
         logic [NSW-1:0] exp_s;
         tick();
         exp_s = (e >= 6) ? 10'h005 : 10'h000;
         n_checks++;
         if (sw_stable !== exp_s || changed_mask !== ((e == 6) ? 10'h005 : 10'h000) || sw_changed !== (e == 6))
            $display("FAIL pattern_005 e=%0d stable=%h mask=%h chg=%b required %h", e, sw_stable, changed_mask, sw_changed, exp_s);
         else n_pass++;
      end
   endtask

   task automatic test_staggered();
      do_reset();
      sw_raw = 10'h001;
      for (int e = 0; e <= 9; e++) begin
         logic [NSW-1:0] exp_s;
         logic [NSW-1:0] exp_m;
         if (e == 2) sw_raw = 10'h003;
         tick();
         exp_s = (e >= 7) ? 10'h003 : ((e >= 5) ? 10'h001 : 10'h000);
         exp_m = (e == 5) ? 10'h001 : ((e == 7) ? 10'h002 : 10'h000);
         n_checks++;
         if (sw_stable !== exp_s || changed_mask !== exp_m || sw_changed !== (exp_m != 10'h000))
            $display("FAIL staggered e=%0d stable=%h mask=%h chg=%b required %h/%h", e, sw_stable, changed_mask, sw_changed, exp_s, exp_m);
         else n_pass++;
         n_checks++;
         if (sw_stable !== m_stable || changed_mask !== m_mask || sw_changed !== m_changed)
            $display("FAIL staggered_model e=%0d stable=%h/%h mask=%h/%h", e, sw_stable, m_stable, changed_mask, m_mask);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      sw_raw = 10'h020;
      for (int e = 0; e < 4; e++) tick();
      reset = 1'b1;
      tick();
      n_checks++;
      if (sw_stable !== 10'h000)
         $display("FAIL reset_mid_hold stable=%h required 000", sw_stable);
      else n_pass++;
      reset = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         tick();
         n_checks++;
         if (sw_stable[5] !== (e >= 6) || sw_stable !== m_stable)
            $display("FAIL reset_mid e=%0d stable=%h required bit5=%b", e, sw_stable, (e >= 6));
         else n_pass++;
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) reset = 1'b1;
         if (c == 1502) reset = 1'b0;
         if ($urandom_range(0, 3) == 0) sw_raw = sw_raw ^ NSW'($urandom());
         tick();
         n_checks++;
         if (sw_stable !== m_stable || changed_mask !== m_mask || sw_changed !== m_changed)
            $display("FAIL random c=%0d stable=%h/%h mask=%h/%h chg=%b/%b", c, sw_stable, m_stable, changed_mask, m_mask, sw_changed, m_changed);
         else n_pass++;
`ifdef SW_GLITCH_COUNT_EN
         n_checks++;
         if (glitch_count !== m_glitch)
            $display("FAIL random_glitch c=%0d got=%0d required %0d", c, glitch_count, m_glitch);
         else n_pass++;
`endif
      end
   endtask

`ifdef SW_GLITCH_COUNT_EN
   task automatic test_glitch_sat();
      int bad;
      bad = 0;
      do_reset();
      for (int c = 0; c < 70000; c++) begin
         sw_raw = (c % 2 == 0) ? 10'h001 : 10'h002;
         tick();
         if (glitch_count !== m_glitch) bad++;
      end
      n_checks++;
      if (bad != 0 || glitch_count !== 16'hFFFF)
         $display("FAIL glitch_sat got=%h required FFFF mismatched_cycles=%0d", glitch_count, bad);
      else n_pass++;
      for (int c = 0; c < 10; c++) begin
         sw_raw = (c % 2 == 0) ? 10'h001 : 10'h002;
         tick();
      end
      n_checks++;
      if (glitch_count !== 16'hFFFF)
         $display("FAIL glitch_sat_hold got=%h required FFFF", glitch_count);
      else n_pass++;
   endtask
`endif

   initial begin
      reset  = 1'b1;
      sw_raw = '0;
      test_reset();
      test_glitch();
      test_pattern_005();
      test_staggered();
      test_reset_mid();
      test_random();
`ifdef SW_GLITCH_COUNT_EN
      test_glitch_sat();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
